run_clk_ctrl: RTL and testbench
===============================

RUN_CLK_CTRL -- requirements
Module: run_clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the divider count and of div_i.
REQ-002 SHALL have parameter PC_W, default 32: width of the PC compare path.
REQ-003 SHALL have parameter NUM_BP, default 4, legal range 1..16: number of breakpoint channels.
REQ-004 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port div_i, input, DIV_W: half-period of clk_run_o in clk_i cycles, minus one.
REQ-007 SHALL have port run_i, input, 1: level request for free-run.
REQ-008 SHALL have port step_i, input, 1: one-cycle pulse requesting a single step.
REQ-009 SHALL have port halt_i, input, 1: one-cycle pulse requesting a stop.
REQ-010 SHALL have port clr_i, input, 1: one-cycle pulse that leaves HALT and clears the sticky flags.
REQ-011 SHALL have port pc_i, input, PC_W: current core PC.
REQ-012 SHALL have port bp_en_i, input, NUM_BP: per-channel breakpoint enable.
REQ-013 SHALL have port bp_addr_i, input, NUM_BP*PC_W: breakpoint addresses; channel k occupies bits [k*PC_W +: PC_W].
REQ-014 SHALL have port pc_limit_i, input, PC_W: PC overflow boundary.
REQ-015 SHALL have port clk_run_o, output, 1: gated, divided run clock for the core.
REQ-016 SHALL have port run_rise_o, output, 1: one-clk_i strobe, asserted in the cycle clk_run_o goes 0->1.
REQ-017 SHALL have port state_o, output, 2: IDLE=00, RUN=01, STEP=10, HALT=11.
REQ-018 SHALL have port bp_hit_o, output, NUM_BP: sticky per-channel hit flags.
REQ-019 SHALL have port ov_o, output, 1: sticky PC-overflow flag.
REQ-020 SHALL have port cycle_cnt_o, output, 32: count of rising edges of clk_run_o.

Function
REQ-021 Divider SHALL count cnt from 0 to div_i and reset to 0 at terminal count (cnt==div_i); phase SHALL toggle at terminal count, and clk_run_o SHALL equal phase.
REQ-022 div_i SHALL be compared live at every cycle, so a change takes effect in the current half-period; div_i=0 SHALL toggle every clk_i cycle.
REQ-023 A rising toggle (phase 0->1) SHALL be issued only in RUN or STEP.
REQ-024 A falling toggle SHALL always be completed; in IDLE/HALT, clk_run_o SHALL remain high for at most div_i+1 cycles and then stay low.
REQ-025 In IDLE/HALT with phase=0, cnt SHALL be held at 0.
REQ-026 Command priority SHALL be halt_i > clr_i > step_i > run_i.
REQ-027 IDLE SHALL go to STEP on step_i and to RUN on run_i=1.
REQ-028 RUN SHALL go to IDLE on halt_i or run_i=0.
REQ-029 STEP SHALL go to IDLE on halt_i, and otherwise in the cycle its single falling toggle completes.
REQ-030 HALT SHALL ignore run_i and step_i, and SHALL go to IDLE only on clr_i.
REQ-031 Stop check: in RUN/STEP, on the cycle a rising toggle would occur, pc_i SHALL be compared against each channel k with bp_en_i[k]=1 and against pc_limit_i (pc_i >= pc_limit_i, unsigned).
REQ-032 Stop check result: on any match the rising toggle SHALL be suppressed, state SHALL become HALT, and every matching bp_hit_o bit and/or ov_o SHALL be set in the same cycle; simultaneous matches SHALL all be flagged.
REQ-033 Resume override: the first rising toggle after entering RUN or STEP from IDLE SHALL skip the breakpoint compare (not the limit compare).
REQ-034 run_rise_o SHALL be combinational with the rising toggle, i.e. high in the clk_i cycle in which clk_run_o registers 1.
REQ-035 cycle_cnt_o SHALL increment on each rising toggle and wrap 0xFFFFFFFF->0.
REQ-036 clr_i SHALL zero bp_hit_o and ov_o, and SHALL NOT clear cycle_cnt_o.

Reset
REQ-037 While rst_i=1 at a clk_i edge: cnt=0, phase=0, clk_run_o=0, run_rise_o=0, state_o=IDLE, bp_hit_o=0, ov_o=0, cycle_cnt_o=0, resume override armed.
REQ-038 Reset mid-operation (any state or phase) SHALL take effect on the next clk_i edge with no completing toggle.

Verification
REQ-039 Free-run: div_i=24, run_i=1 from reset -> RUN next cycle; first clk_run_o rise 25 cycles later; period 50, 50% duty; cycle_cnt_o=4 after 4 rises.
REQ-040 Step: div_i=0, step_i pulse in IDLE -> exactly one high cycle of clk_run_o, one run_rise_o, state back to IDLE; a second step_i gives a second single pulse.
REQ-041 Breakpoint: bp_en_i=0001, bp0=0x48, run, pc_i driven to 0x48 -> no further rise, state=HALT, bp_hit_o=0001; clr_i then run_i -> next rise issued (override) with pc_i=0x48.
REQ-042 Overflow: pc_limit_i=0x48, pc_i=0x48, bp0 also 0x48 and enabled -> HALT with ov_o=1 and bp_hit_o=0001 in the same cycle.
REQ-043 Halt mid-high: div_i=3, halt_i while clk_run_o=1 -> IDLE immediately, clk_run_o falls at terminal count, then stays 0; halt_i+step_i same cycle -> no step.
REQ-044 Reset mid-run: rst_i during high phase, cycle_cnt_o=7 -> next cycle all outputs at REQ-037 values.

Source files
------------

// File: rtl/run_clk_ctrl.sv
// run_clk_ctrl: divided, gated run clock for a core with run/step/halt control,
// per-channel PC breakpoints, a PC overflow limit and a rising-edge counter.
module run_clk_ctrl #(
   parameter int DIV_W  = 8,
   parameter int PC_W   = 32,
   parameter int NUM_BP = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [DIV_W-1:0]       div_i,
   input  logic                   run_i,
   input  logic                   step_i,
   input  logic                   halt_i,
   input  logic                   clr_i,
   input  logic [PC_W-1:0]        pc_i,
   input  logic [NUM_BP-1:0]      bp_en_i,
   input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
   input  logic [PC_W-1:0]        pc_limit_i,
   output logic                   clk_run_o,
   output logic                   run_rise_o,
   output logic [1:0]             state_o,
   output logic [NUM_BP-1:0]      bp_hit_o,
   output logic                   ov_o,
   output logic [31:0]            cycle_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } state_t;

   state_t            state_reg, state_next;
   logic [DIV_W-1:0]  cnt_reg, cnt_next;
   logic              phase_reg, phase_next;
   logic [NUM_BP-1:0] bp_hit_reg, bp_hit_next;
   logic              ov_reg, ov_next;
   logic [31:0]       cycle_cnt_reg, cycle_cnt_next;
   // set on entry to RUN/STEP from IDLE: the first rise ignores breakpoints
   logic              override_reg, override_next;
   // marks that a STEP has issued its single rise, so the next fall ends it
   logic              step_rose_reg, step_rose_next;

   logic              tc;
   logic              run_state;
   logic              may_rise;
   logic              attempt;
   logic              fall;
   logic              rise;
   logic              stop;
   logic              ov_match;
   logic              clr_cmd;
   logic [NUM_BP-1:0] bp_match;

   // terminal count is compared live against div_i
   assign tc        = (cnt_reg == div_i);
   assign run_state = (state_reg == ST_RUN) || (state_reg == ST_STEP);
   // a rise is only attempted if this cycle's commands keep the state running
   assign may_rise  = ((state_reg == ST_RUN) && run_i && !halt_i) ||
                      ((state_reg == ST_STEP) && !halt_i);
   assign attempt   = !phase_reg && tc && may_rise;
   assign fall      = phase_reg && tc;
   assign clr_cmd   = clr_i && !halt_i;

   // per-channel breakpoint compare, masked while the resume override is armed
   generate
      for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
         assign bp_match[gi] = bp_en_i[gi] && !override_reg &&
                               (bp_addr_i[gi*PC_W +: PC_W] == pc_i);
      end
   endgenerate

   assign ov_match = (pc_i >= pc_limit_i);
   assign stop     = attempt && ((|bp_match) || ov_match);
   assign rise     = attempt && !stop;

   // divider count, clock phase and rising-edge counter
   always_comb begin
      cnt_next       = cnt_reg;
      phase_next     = phase_reg;
      cycle_cnt_next = cycle_cnt_reg;
      if (!phase_reg && !run_state) begin
         cnt_next = '0;
      end else if (tc) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
      if (rise) begin
         phase_next     = 1'b1;
         cycle_cnt_next = cycle_cnt_reg + 32'd1;
      end else if (fall) begin
         phase_next = 1'b0;
      end
   end

   // sticky hit/overflow flags: clear first, then record every match of a stop
   always_comb begin
      bp_hit_next = clr_cmd ? '0 : bp_hit_reg;
      ov_next     = clr_cmd ? 1'b0 : ov_reg;
      if (stop) begin
         bp_hit_next = bp_hit_next | bp_match;
         ov_next     = ov_next | ov_match;
      end
   end

   // control FSM next state, resume override and step bookkeeping
   always_comb begin
      state_next     = state_reg;
      override_next  = override_reg;
      step_rose_next = step_rose_reg;
      if (attempt) begin
         override_next = 1'b0;
      end
      if (rise && (state_reg == ST_STEP)) begin
         step_rose_next = 1'b1;
      end
      if (stop) begin
         state_next = ST_HALT;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!halt_i && !clr_i) begin
                  if (step_i) begin
                     state_next     = ST_STEP;
                     override_next  = 1'b1;
                     step_rose_next = 1'b0;
                  end else if (run_i) begin
                     state_next    = ST_RUN;
                     override_next = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (halt_i || !run_i) begin
                  state_next = ST_IDLE;
               end
            end
            ST_STEP: begin
               if (halt_i) begin
                  state_next = ST_IDLE;
               end else if (fall && step_rose_reg) begin
                  state_next = ST_IDLE;
               end
            end
            ST_HALT: begin
               if (clr_cmd) begin
                  state_next = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // register update with synchronous reset; reset drops the clock with no completing toggle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         phase_reg     <= 1'b0;
         bp_hit_reg    <= '0;
         ov_reg        <= 1'b0;
         cycle_cnt_reg <= '0;
         override_reg  <= 1'b1;
         step_rose_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         phase_reg     <= phase_next;
         bp_hit_reg    <= bp_hit_next;
         ov_reg        <= ov_next;
         cycle_cnt_reg <= cycle_cnt_next;
         override_reg  <= override_next;
         step_rose_reg <= step_rose_next;
      end
   end

   assign clk_run_o   = phase_reg;
   assign run_rise_o  = rise && !rst_i;
   assign state_o     = state_reg;
   assign bp_hit_o    = bp_hit_reg;
   assign ov_o        = ov_reg;
   assign cycle_cnt_o = cycle_cnt_reg;

endmodule

// File: tb/tb_run_clk_ctrl.sv
// tb_run_clk_ctrl: directed stimulus, cycle-by-cycle comparison against a
// behavioural model, plus hand-computed literal expectations.
module tb_run_clk_ctrl;

   logic         clk;
   logic         rst_i;
   logic [7:0]   div_i;
   logic         run_i;
   logic         step_i;
   logic         halt_i;
   logic         clr_i;
   logic [31:0]  pc_i;
   logic [3:0]   bp_en_i;
   logic [127:0] bp_addr_i;
   logic [31:0]  pc_limit_i;
   logic         clk_run_o;
   logic         run_rise_o;
   logic [1:0]   state_o;
   logic [3:0]   bp_hit_o;
   logic         ov_o;
   logic [31:0]  cycle_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;

   run_clk_ctrl #(.DIV_W(8), .PC_W(32), .NUM_BP(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .div_i      (div_i),
      .run_i      (run_i),
      .step_i     (step_i),
      .halt_i     (halt_i),
      .clr_i      (clr_i),
      .pc_i       (pc_i),
      .bp_en_i    (bp_en_i),
      .bp_addr_i  (bp_addr_i),
      .pc_limit_i (pc_limit_i),
      .clk_run_o  (clk_run_o),
      .run_rise_o (run_rise_o),
      .state_o    (state_o),
      .bp_hit_o   (bp_hit_o),
      .ov_o       (ov_o),
      .cycle_cnt_o(cycle_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // quiet per-cycle comparison
   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // literal expectation, one line per check
   task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end else begin
         $display("ok   %s = %0h", name, got);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_cnt;
   bit       m_phase;
   bit [1:0] m_state;   // 0 idle, 1 run, 2 step, 3 halt
   bit [3:0] m_bp;
   bit       m_ov;
   bit [31:0] m_cyc;
   bit       m_ovr;
   bit       m_stepped;
   bit       m_valid = 1'b0;

   function automatic bit m_attempt();
      bit keep;
      keep = ((m_state == 2'd1) && run_i && !halt_i) || ((m_state == 2'd2) && !halt_i);
      return !m_phase && (m_cnt == int'(div_i)) && keep;
   endfunction

   function automatic bit [3:0] m_bp_match();
      bit [3:0] r;
      r = 4'b0;
      for (int k = 0; k < 4; k++)
         if (bp_en_i[k] && !m_ovr && (bp_addr_i[k*32 +: 32] == pc_i)) r[k] = 1'b1;
      return r;
   endfunction

   function automatic bit m_ov_match();
      return pc_i >= pc_limit_i;
   endfunction

   function automatic bit m_rise();
      return m_attempt() && (m_bp_match() == 4'b0) && !m_ov_match();
   endfunction

   always @(posedge clk) begin
      bit att, stp, rs, fl, om;
      bit [3:0] bm;
      bit [1:0] ns;
      if (rst_i) begin
         m_cnt = 0; m_phase = 0; m_state = 0; m_bp = 0; m_ov = 0;
         m_cyc = 0; m_ovr = 1; m_stepped = 0; m_valid = 1;
      end else begin
         att = m_attempt();
         bm  = m_bp_match();
         om  = m_ov_match();
         stp = att && ((bm != 4'b0) || om);
         rs  = att && !stp;
         fl  = m_phase && (m_cnt == int'(div_i));
         if (clr_i && !halt_i) begin m_bp = 0; m_ov = 0; end
         if (stp) begin m_bp = m_bp | bm; m_ov = m_ov | om; end
         ns = m_state;
         if (stp) ns = 2'd3;
         else begin
            case (m_state)
               2'd0: if (!halt_i && !clr_i) begin
                        if (step_i) ns = 2'd2;
                        else if (run_i) ns = 2'd1;
                     end
               2'd1: if (halt_i || !run_i) ns = 2'd0;
               2'd2: if (halt_i || (fl && m_stepped)) ns = 2'd0;
               default: if (clr_i && !halt_i) ns = 2'd0;
            endcase
         end
         if (att) m_ovr = 0;
         if ((m_state == 2'd0) && (ns != 2'd0)) m_ovr = 1;
         if ((m_state == 2'd0) && (ns == 2'd2)) m_stepped = 0;
         if (rs && (m_state == 2'd2)) m_stepped = 1;
         if (!m_phase && !((m_state == 2'd1) || (m_state == 2'd2))) m_cnt = 0;
         else if (m_cnt == int'(div_i)) m_cnt = 0;
         else m_cnt = (m_cnt + 1) % 256;
         if (rs) begin m_phase = 1; m_cyc = m_cyc + 1; end
         else if (fl) m_phase = 0;
         m_state = ns;
      end
   end

   // compare process on the opposite edge
   always @(negedge clk) begin
      if (m_valid) begin
         cmp("clk_run_o",   {31'b0, clk_run_o},  {31'b0, m_phase});
         cmp("run_rise_o",  {31'b0, run_rise_o}, {31'b0, (rst_i ? 1'b0 : m_rise())});
         cmp("state_o",     {30'b0, state_o},    {30'b0, m_state});
         cmp("bp_hit_o",    {28'b0, bp_hit_o},   {28'b0, m_bp});
         cmp("ov_o",        {31'b0, ov_o},       {31'b0, m_ov});
         cmp("cycle_cnt_o", cycle_cnt_o,         m_cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_i = 1; div_i = 8'd24; run_i = 0; step_i = 0; halt_i = 0; clr_i = 0;
      pc_i = 0; bp_en_i = 0; bp_addr_i = '0; pc_limit_i = 32'hFFFF_FFFF;
      tickn(3);
      expect_val("reset_state",     {30'b0, state_o},   32'd0);
      expect_val("reset_clk_run",   {31'b0, clk_run_o}, 32'd0);
      expect_val("reset_cycle_cnt", cycle_cnt_o,        32'd0);

      // free-run, div 24
      rst_i = 0; run_i = 1;
      tick();
      expect_val("run_entry_state", {30'b0, state_o}, 32'd1);
      tickn(24);
      expect_val("pre_rise_clk",    {31'b0, clk_run_o},  32'd0);
      expect_val("pre_rise_strobe", {31'b0, run_rise_o}, 32'd1);
      tick();
      expect_val("first_rise_clk",  {31'b0, clk_run_o}, 32'd1);
      expect_val("first_rise_cnt",  cycle_cnt_o,        32'd1);
      tickn(24);
      expect_val("high_end_clk",    {31'b0, clk_run_o}, 32'd1);
      tick();
      expect_val("fall_clk",        {31'b0, clk_run_o}, 32'd0);
      tickn(24);
      expect_val("low_end_clk",     {31'b0, clk_run_o}, 32'd0);
      tick();
      expect_val("second_rise_clk", {31'b0, clk_run_o}, 32'd1);
      tickn(100);
      expect_val("four_rises_cnt",  cycle_cnt_o, 32'd4);
      run_i = 0;
      tickn(30);
      expect_val("stop_state",      {30'b0, state_o},   32'd0);
      expect_val("stop_clk",        {31'b0, clk_run_o}, 32'd0);

      // single steps, div 0
      div_i = 8'd0; step_i = 1;
      tick();
      step_i = 0;
      expect_val("step_state",      {30'b0, state_o},    32'd2);
      expect_val("step_strobe",     {31'b0, run_rise_o}, 32'd1);
      tick();
      expect_val("step_high",       {31'b0, clk_run_o},  32'd1);
      tick();
      expect_val("step_low",        {31'b0, clk_run_o},  32'd0);
      expect_val("step_done_state", {30'b0, state_o},    32'd0);
      expect_val("step_cnt",        cycle_cnt_o,         32'd5);
      tickn(3);
      step_i = 1;
      tick();
      step_i = 0;
      tick();
      expect_val("step2_high",      {31'b0, clk_run_o},  32'd1);
      tick();
      expect_val("step2_low",       {31'b0, clk_run_o},  32'd0);
      expect_val("step2_cnt",       cycle_cnt_o,         32'd6);

      // breakpoint channel 0 at 0x48
      div_i = 8'd1; bp_en_i = 4'b0001; bp_addr_i[31:0] = 32'h48; pc_i = 32'h10; run_i = 1;
      for (int i = 0; i < 20 && clk_run_o !== 1'b1; i++) tick();
      expect_val("bp_first_rise",   {31'b0, clk_run_o}, 32'd1);
      pc_i = 32'h48;
      for (int i = 0; i < 20 && state_o !== 2'd3; i++) tick();
      expect_val("bp_halt_state",   {30'b0, state_o},  32'd3);
      expect_val("bp_hit",          {28'b0, bp_hit_o}, 32'd1);
      expect_val("bp_no_ov",        {31'b0, ov_o},     32'd0);
      tickn(5);
      expect_val("bp_held_low",     {31'b0, clk_run_o}, 32'd0);
      expect_val("bp_still_halt",   {30'b0, state_o},   32'd3);
      clr_i = 1;
      tick();
      clr_i = 0;
      expect_val("clr_state",       {30'b0, state_o},  32'd0);
      expect_val("clr_bp_hit",      {28'b0, bp_hit_o}, 32'd0);
      for (int i = 0; i < 20 && clk_run_o !== 1'b1; i++) tick();
      expect_val("override_rise",   {31'b0, clk_run_o}, 32'd1);
      expect_val("override_state",  {30'b0, state_o},   32'd1);
      run_i = 0;
      for (int i = 0; i < 20 && !(state_o === 2'd0 && clk_run_o === 1'b0); i++) tick();
      expect_val("bp_exit_clk",     {31'b0, clk_run_o}, 32'd0);

      // overflow together with breakpoint
      pc_i = 32'h10; pc_limit_i = 32'h48; run_i = 1;
      for (int i = 0; i < 20 && clk_run_o !== 1'b1; i++) tick();
      expect_val("ov_first_rise",   {31'b0, clk_run_o}, 32'd1);
      pc_i = 32'h48;
      for (int i = 0; i < 20 && state_o !== 2'd3; i++) tick();
      expect_val("ov_halt_state",   {30'b0, state_o},  32'd3);
      expect_val("ov_flag",         {31'b0, ov_o},     32'd1);
      expect_val("ov_bp_hit",       {28'b0, bp_hit_o}, 32'd1);
      run_i = 0; clr_i = 1;
      tick();
      clr_i = 0;
      expect_val("ov_clr",          {31'b0, ov_o},     32'd0);
      pc_limit_i = 32'hFFFF_FFFF; bp_en_i = 4'b0; pc_i = 32'h0;

      // halt while high, div 3
      div_i = 8'd3; run_i = 1;
      for (int i = 0; i < 20 && clk_run_o !== 1'b1; i++) tick();
      halt_i = 1; run_i = 0;
      tick();
      halt_i = 0;
      expect_val("halt_state",      {30'b0, state_o},   32'd0);
      expect_val("halt_still_high", {31'b0, clk_run_o}, 32'd1);
      tickn(3);
      expect_val("halt_fell",       {31'b0, clk_run_o}, 32'd0);
      tickn(10);
      expect_val("halt_stays_low",  {31'b0, clk_run_o}, 32'd0);
      halt_i = 1; step_i = 1;
      tick();
      halt_i = 0; step_i = 0;
      expect_val("halt_beats_step", {30'b0, state_o}, 32'd0);
      tickn(5);
      expect_val("no_step_clk",     {31'b0, clk_run_o}, 32'd0);
      expect_val("no_step_cnt",     cycle_cnt_o,        32'd10);

      // reset in the high phase with seven rises counted
      rst_i = 1;
      tick();
      rst_i = 0; div_i = 8'd0; run_i = 1;
      for (int i = 0; i < 100 && cycle_cnt_o !== 32'd7; i++) tick();
      expect_val("pre_rst_cnt",     cycle_cnt_o,        32'd7);
      expect_val("pre_rst_high",    {31'b0, clk_run_o}, 32'd1);
      rst_i = 1;
      tick();
      expect_val("rst_clk_run",     {31'b0, clk_run_o},  32'd0);
      expect_val("rst_run_rise",    {31'b0, run_rise_o}, 32'd0);
      expect_val("rst_state",       {30'b0, state_o},    32'd0);
      expect_val("rst_bp_hit",      {28'b0, bp_hit_o},   32'd0);
      expect_val("rst_ov",          {31'b0, ov_o},       32'd0);
      expect_val("rst_cycle_cnt",   cycle_cnt_o,         32'd0);
      rst_i = 0; run_i = 0;
      tickn(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
